// File: rtl/ram_pkg.sv
// Shared constants and types for the 16K x 16 RAM and its 4K banks.
package ram_pkg;
  localparam int RAM_DATA_W = 16;
  localparam int RAM_ADDR_W = 14;
  localparam int RAM_DEPTH  = 16384;
  localparam int RAM_BANKS  = 4;

  typedef logic [RAM_DATA_W-1:0] word_t;
endpackage

// File: rtl/ram_4k.sv
// 4K x 16 bank: synchronous write, combinational read, per-word valid bits
// cleared asynchronously so unwritten words read as zero.
module ram_4k
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic              run;
  logic              wr_en;

  // run stays low on the edge that coincides with reset release, so that
  // edge's write is dropped and writes resume on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  assign wr_en = load && run;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[address] <= in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[address] <= 1'b1;
    end
  end

  assign out = valid[address] ? mem[address] : '0;
endmodule

// File: rtl/ram_16k.sv
// 16K x 16 RAM built from four 4K banks; the top address bits pick the bank
// for both the write enable and the read mux.
module ram_16k
  import ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out
);
  localparam int SEL_W   = $clog2(RAM_BANKS);
  localparam int BANK_AW = ADDR_W - SEL_W;

  logic [SEL_W-1:0]   sel;
  logic [BANK_AW-1:0] bank_addr;
  logic [RAM_BANKS-1:0] bank_load;
  logic [DATA_W-1:0]  bank_out [RAM_BANKS];

  assign sel       = address[ADDR_W-1 -: SEL_W];
  assign bank_addr = address[BANK_AW-1:0];

  for (genvar b = 0; b < RAM_BANKS; b++) begin : g_bank
    assign bank_load[b] = load && (sel == SEL_W'(b));

    ram_4k #(
      .DATA_W (DATA_W),
      .ADDR_W (BANK_AW)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .in      (in),
      .load    (bank_load[b]),
      .address (bank_addr),
      .out     (bank_out[b])
    );
  end

  assign out = bank_out[sel];
endmodule

// File: tb/tb_ram_16k.sv
// Directed bench for ram_16k: stimulus pushes expected read values into a
// queue, a monitor pops and compares them against out.
module tb_ram_16k;
  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [13:0] address;
  logic [15:0] out;

  logic [15:0] exp_q[$];
  string       name_q[$];
  event        chk_ev;
  int          pass_cnt;
  int          total_cnt;

  ram_16k dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        logic [15:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        total_cnt++;
        if (out === e) begin
          pass_cnt++;
        end else begin
          $display("FAIL %s: out=%h expected=%h (address=%h)", n, out, e, address);
        end
      end
    end
  end

  // driver tasks
  task automatic expect_out(input string n, input logic [15:0] e);
    exp_q.push_back(e);
    name_q.push_back(n);
    #1;
    -> chk_ev;
    #1;
  endtask

  task automatic drive(input logic ld, input logic [15:0] d, input logic [13:0] a);
    @(negedge clk);
    load    = ld;
    in      = d;
    address = a;
  endtask

  task automatic write_word(input logic [13:0] a, input logic [15:0] d);
    drive(1'b1, d, a);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic read_check(input string n, input logic [13:0] a, input logic [15:0] e);
    drive(1'b0, 16'h0000, a);
    expect_out(n, e);
  endtask

  initial begin
    rst_n   = 1'b1;
    load    = 1'b0;
    in      = 16'h0000;
    address = '0;
    #2;
    // 1: reset then read
    rst_n   = 1'b0;
    in      = 16'hAAAA;
    address = 14'h0028;
    expect_out("reset_out", 16'h0000);
    repeat (2) begin
      @(negedge clk);
      expect_out("reset_hold", 16'h0000);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      expect_out("post_reset_read", 16'h0000);
    end

    // 2: basic write, no write-through before the edge
    drive(1'b1, 16'hABCD, 14'h0028);
    expect_out("pre_edge_no_bypass", 16'h0000);
    @(posedge clk);
    expect_out("post_edge_write", 16'hABCD);
    @(posedge clk);
    expect_out("load_held_idempotent", 16'hABCD);
    @(negedge clk);
    load = 1'b0;

    // 3: untouched location
    read_check("untouched_0414", 14'h0414, 16'h0000);

    // 4: retention
    read_check("retain_c1", 14'h0028, 16'hABCD);
    @(negedge clk);
    expect_out("retain_c2", 16'hABCD);

    // 5: bank boundaries and isolation
    write_word(14'h0FFF, 16'h1111);
    write_word(14'h1000, 16'h2222);
    write_word(14'h3FFF, 16'h3333);
    write_word(14'h0000, 16'h4444);
    read_check("rd_0FFF", 14'h0FFF, 16'h1111);
    read_check("rd_1000", 14'h1000, 16'h2222);
    read_check("rd_3FFF", 14'h3FFF, 16'h3333);
    read_check("rd_0000", 14'h0000, 16'h4444);
    read_check("nb_0FFE", 14'h0FFE, 16'h0000);
    read_check("nb_1001", 14'h1001, 16'h0000);
    read_check("alias_1028", 14'h1028, 16'h0000);
    read_check("alias_2028", 14'h2028, 16'h0000);
    read_check("alias_3028", 14'h3028, 16'h0000);
    read_check("rd_0028_again", 14'h0028, 16'hABCD);

    // 6: async reset mid-cycle, writes ignored during reset
    read_check("pre_rst_0FFF", 14'h0FFF, 16'h1111);
    #1;
    rst_n = 1'b0;
    expect_out("async_rst_drop", 16'h0000);
    drive(1'b1, 16'h5555, 14'h0FFF);
    @(posedge clk);
    expect_out("write_in_reset", 16'h0000);
    @(posedge clk);
    rst_n = 1'b1;
    expect_out("release_edge_write", 16'h0000);
    @(negedge clk);
    expect_out("release_edge_hold", 16'h0000);
    @(posedge clk);
    expect_out("resume_write", 16'h5555);
    @(negedge clk);
    load = 1'b0;
    read_check("post_rst_1000", 14'h1000, 16'h0000);
    read_check("post_rst_0028", 14'h0028, 16'h0000);
    read_check("post_rst_0FFF", 14'h0FFF, 16'h5555);

    #20;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
      total_cnt++;
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
